// File: rtl/push_debouncer.sv
// -----------------------------------------------------------------------------
// push_debouncer
//
// Turns a raw, bouncy single-bit input into a clean registered level. It also
// emits one-cycle pulses on each validated edge. It feeds an enable-DFF storage
// stage: o_rise is that stage's write enable and o_data is its data input.
// The held bit therefore only changes on a debounced edge.
//
// A change on the sampled input is accepted only after it has differed from
// o_data for STABLE_CYCLES consecutive rising edges. Any edge where the sample
// agrees with o_data aborts the count with no output change.
//
// Optional build macro:
//   PUSH_DEBOUNCER_SYNC_EN  - puts a two-flop synchronizer on i_data ahead of
//                             the counter. This adds 2 cycles of latency.
//                             Undefined: i_data is sampled directly and must
//                             already be synchronous to i_clk.
//
// Parameters:
//   STABLE_CYCLES  consecutive differing samples needed (1 .. 2^CNT_WIDTH-1)
//   CNT_WIDTH      width of the stability counter
//
// Ports:
//   i_clk   in   system clock, rising edge
//   i_rst   in   synchronous, active-high reset
//   i_data  in   raw input
//   o_data  out  debounced level (registered)
//   o_rise  out  one-cycle pulse coincident with o_data 0->1
//   o_fall  out  one-cycle pulse coincident with o_data 1->0
//   o_busy  out  high while a candidate change is being counted
// -----------------------------------------------------------------------------
module push_debouncer #(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned CNT_WIDTH     = 8
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_data,
  output logic o_data,
  output logic o_rise,
  output logic o_fall,
  output logic o_busy
);

  // The counter value alone encodes the state. The enum names it for readers.
  typedef enum logic {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } state_e;

  // The counter reaches this value on the edge that accepts the change.
  // It therefore never exceeds STABLE_CYCLES-1 and never wraps.
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(STABLE_CYCLES - 1);

  logic s;  // sampled input seen by the counter logic

`ifdef PUSH_DEBOUNCER_SYNC_EN
  logic sync1_q;
  logic sync2_q;

  // Two-flop synchronizer. Both stages clear on reset so that, after release,
  // the first comparison is against a known 0 rather than a stale pin value.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= i_data;
      sync2_q <= sync1_q;
    end
  end

  assign s = sync2_q;
`else
  assign s = i_data;
`endif

  logic                 data_q, data_d;
  logic                 rise_q, rise_d;
  logic                 fall_q, fall_d;
  logic [CNT_WIDTH-1:0] cnt_q,  cnt_d;
  state_e               state;

  assign state = (cnt_q != '0) ? COUNT : IDLE;

  // Next-state logic. The behaviour is identical in IDLE and COUNT. The only
  // question is whether the sample still disagrees with the held level, and
  // whether this edge completes the run.
  always_comb begin
    // NOTE: every output of this block gets a default first, so that no path
    // leaves a variable unassigned and a latch is never inferred.
    data_d = data_q;
    rise_d = 1'b0;
    fall_d = 1'b0;
    cnt_d  = cnt_q;

    if (s == data_q) begin
      // The input agrees with the held level, either at rest or as a bounce
      // back. Drop any partial count.
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      // The run is complete. Accept the new level and flag the edge.
      data_d = s;
      rise_d = s;
      fall_d = ~s;
      cnt_d  = '0;
    end else begin
      cnt_d = cnt_q + CNT_WIDTH'(1);
    end
  end

  // State register. The reset is synchronous and wins over everything else.
  always_ff @(posedge i_clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    if (i_rst) begin
      data_q <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      data_q <= data_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
      cnt_q  <= cnt_d;
    end
  end

  assign o_data = data_q;
  assign o_rise = rise_q;
  assign o_fall = fall_q;
  assign o_busy = (state == COUNT);

endmodule

// File: tb/tb_push_debouncer.sv
// -----------------------------------------------------------------------------
// tb_push_debouncer
//
// Self-checking bench for push_debouncer (STABLE_CYCLES=4). A second instance
// with STABLE_CYCLES=1 exercises the pass-through boundary. Inputs change on
// the falling edge and outputs are sampled on the falling edge after each
// rising edge. With PUSH_DEBOUNCER_SYNC_EN defined, the expectations shift by
// the 2-edge synchronizer latency.
// -----------------------------------------------------------------------------
`timescale 1ns/1ns
module tb_push_debouncer;

  localparam int unsigned STABLE = 4;
`ifdef PUSH_DEBOUNCER_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic clk    = 1'b0;
  logic i_rst  = 1'b1;
  logic i_data = 1'b0;
  logic o_data, o_rise, o_fall, o_busy;
  logic o1_data, o1_rise, o1_fall, o1_busy;

  push_debouncer #(.STABLE_CYCLES(STABLE), .CNT_WIDTH(8)) dut (
    .i_clk (clk),
    .i_rst (i_rst),
    .i_data(i_data),
    .o_data(o_data),
    .o_rise(o_rise),
    .o_fall(o_fall),
    .o_busy(o_busy)
  );

  push_debouncer #(.STABLE_CYCLES(1), .CNT_WIDTH(8)) dut1 (
    .i_clk (clk),
    .i_rst (i_rst),
    .i_data(i_data),
    .o_data(o1_data),
    .o_rise(o1_rise),
    .o_fall(o1_fall),
    .o_busy(o1_busy)
  );

  always #1 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model. It keeps the history of samples since the last accepted
  // change. A change is accepted once the last STABLE samples all disagree
  // with the held level. The pipe array models the synchronizer's delay.
  // ---------------------------------------------------------------------------
  bit m_data, m_rise, m_fall, m_busy;
  bit m1_data, m1_rise, m1_fall;
  bit pipe[2];
  bit hist[$];

  function automatic void model_edge(bit rst, bit din);
    bit s;
    int run;
    m_rise  = 1'b0;
    m_fall  = 1'b0;
    m1_rise = 1'b0;
    m1_fall = 1'b0;
    if (rst) begin
      m_data  = 1'b0;
      m_busy  = 1'b0;
      m1_data = 1'b0;
      pipe[0] = 1'b0;
      pipe[1] = 1'b0;
      hist.delete();
      return;
    end
    s = (LAT == 0) ? din : pipe[1];
    pipe[1] = pipe[0];
    pipe[0] = din;

    // Threshold 1: the level follows the sample, pulsing on every change.
    m1_rise = s & ~m1_data;
    m1_fall = ~s & m1_data;
    m1_data = s;

    hist.push_back(s);
    run = 0;
    for (int i = hist.size() - 1; i >= 0 && hist[i] != m_data; i--) run++;
    if (run >= int'(STABLE)) begin
      m_data = s;
      m_rise = s;
      m_fall = ~s;
      hist.delete();
    end
    if (hist.size() > 32) void'(hist.pop_front());
    m_busy = (hist.size() > 0) && (hist[hist.size() - 1] != m_data);
  endfunction

  // Drive one cycle: set inputs, let a rising edge happen, then return at the
  // following falling edge, where outputs are sampled.
  task automatic step(input logic rst, input logic din);
    i_rst  = rst;
    i_data = din;
    @(posedge clk);
    model_edge(rst, din);
    @(negedge clk);
  endtask

  // ---------------------------------------------------------------------------
  // Directed vector table
  // ---------------------------------------------------------------------------
  typedef struct {
    logic       rst;
    logic       din;
    logic [3:0] exp;   // {o_data, o_rise, o_fall, o_busy}
    string      name;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(logic rst, logic din, logic [3:0] exp, string name);
    vec_t v;
    v.rst  = rst;
    v.din  = din;
    v.exp  = exp;
    v.name = name;
    vecs.push_back(v);
  endfunction

  logic [3:0] obs[64];

  task automatic run_seq(input logic [31:0] rst_bits, input logic [31:0] din_bits, input int n);
    for (int i = 0; i < n; i++) begin
      step(rst_bits[i], din_bits[i]);
      obs[i] = {o_data, o_rise, o_fall, o_busy};
    end
  endtask

  initial begin
    logic cur;
    logic r;
    logic d;

    @(negedge clk);

    // Reset held with the input high: everything stays at zero.
    add(1, 1, 4'b0000, "reset_0");
    add(1, 1, 4'b0000, "reset_1");
    // Clean rise (input already high at release). Synchronizer slots come first.
    for (int i = 0; i < LAT; i++) add(0, 1, 4'b0000, "rise_sync");
    add(0, 1, 4'b0001, "rise_k");
    add(0, 1, 4'b0001, "rise_k1");
    add(0, 1, 4'b0001, "rise_k2");
    add(0, 1, 4'b1100, "rise_k3_pulse");
    add(0, 1, 4'b1000, "rise_k4");
    add(0, 1, 4'b1000, "rise_hold");
    // Clean fall.
    for (int i = 0; i < LAT; i++) add(0, 0, 4'b1000, "fall_sync");
    add(0, 0, 4'b1001, "fall_k");
    add(0, 0, 4'b1001, "fall_k1");
    add(0, 0, 4'b1001, "fall_k2");
    add(0, 0, 4'b0010, "fall_k3_pulse");
    add(0, 0, 4'b0000, "fall_k4");
    add(0, 0, 4'b0000, "fall_hold");

    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].din);
      check(vecs[i].name, {o_data, o_rise, o_fall, o_busy}, vecs[i].exp);
    end

    // Bounce: high for 3 edges, low for 1, then held high.
    run_seq(32'h0, 32'hFFFF_FFF7, 9 + LAT);
    for (int i = 0; i < 7; i++) check("bounce_quiet", {1'b0, obs[i + LAT][3:1]}, 4'b0000);
    check("bounce_low_busy", {3'b000, obs[3 + LAT][0]}, 4'b0000);
    check("bounce_rise",     obs[7 + LAT], 4'b1100);
    check("bounce_after",    obs[8 + LAT], 4'b1000);

    // Reset asserted mid-count, input stays high throughout.
    step(1, 0);
    run_seq(32'h4, 32'hFFFF_FFFF, 8 + LAT);
    check("rstmid_busy_before", {3'b000, obs[1][0]}, {3'b000, (LAT == 0)});
    check("rstmid_reset_edge",  obs[2], 4'b0000);
    for (int i = 3; i < 6 + LAT; i++) check("rstmid_no_rise", {1'b0, obs[i][3:1]}, 4'b0000);
    check("rstmid_rise",  obs[6 + LAT], 4'b1100);
    check("rstmid_after", obs[7 + LAT], 4'b1000);

    // Random stimulus with long-ish runs and occasional resets, checked
    // against the model for both thresholds.
    step(1, 0);
    cur = 1'b0;
    for (int i = 0; i < 800; i++) begin
      r = ($urandom_range(63) == 0);
      d = ($urandom_range(3) == 0) ? ~cur : cur;
      cur = d;
      step(r, d);
      check("rand_s4", {o_data, o_rise, o_fall, o_busy}, {m_data, m_rise, m_fall, m_busy});
      check("rand_s1", {o1_data, o1_rise, o1_fall, o1_busy}, {m1_data, m1_rise, m1_fall, 1'b0});
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
